// File: rtl/vga_fb_arbiter_if.sv
// Pixel-writer handshake between a CPU/drawing engine and vga_fb_arbiter.
// The master modport is the writer side; the slave modport is the arbiter side.
`timescale 1ns/1ps
interface vga_fb_arbiter_if #(
   parameter int ADDR_W = 19,
   parameter int PIX_W  = 8
);
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [PIX_W-1:0]  wr_data;
   logic              wr_ack;
   logic              wr_err;

   modport master (
      output wr_req, wr_addr, wr_data,
      input  wr_ack, wr_err
   );

   modport slave (
      input  wr_req, wr_addr, wr_data,
      output wr_ack, wr_err
   );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM scheduler: VGA scan-out reads versus a pixel writer.
// Optional front/back buffering is enabled by defining FB_DOUBLE_BUF_EN.
`timescale 1ns/1ps
module vga_fb_arbiter #(
   parameter int FB_W       = 640,
   parameter int FB_H       = 480,
   parameter int H_DRAW_MIN = 160,
   parameter int ADDR_W     = 19,
   parameter int PIX_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pix_clk,
   input  logic              draw_active,
   input  logic [9:0]        pix_x,
   input  logic [8:0]        pix_y,
   input  logic              screen_end,
   vga_fb_arbiter_if.slave   wr,
`ifdef FB_DOUBLE_BUF_EN
   input  logic              swap_req,
   output logic              front_sel,
   output logic              swap_pending,
   output logic [ADDR_W:0]   mem_addr,
`else
   output logic [ADDR_W-1:0] mem_addr,
`endif
   output logic              mem_we,
   output logic [PIX_W-1:0]  mem_wdata,
   input  logic [PIX_W-1:0]  mem_rdata,
   output logic [PIX_W-1:0]  pix_data,
   output logic              pix_valid
);

`ifdef FB_DOUBLE_BUF_EN
   localparam int MA_W = ADDR_W + 1;
`else
   localparam int MA_W = ADDR_W;
`endif

   localparam logic [31:0]     FB_W_V = 32'(FB_W);
   localparam logic [ADDR_W:0] FB_SZ  = (ADDR_W+1)'(FB_W * FB_H);

   typedef enum logic [1:0] {
      IDLE,
      DRD,
      WR
   } st_t;

   st_t st_q;
   st_t st_d;

   logic              disp_pend;
   logic              wr_go;
   logic              wr_ok;
   logic [ADDR_W-1:0] y_w;
   logic [ADDR_W-1:0] y_mul;
   logic [ADDR_W-1:0] x_off;
   logic [ADDR_W-1:0] disp_addr;
   logic [MA_W-1:0]   rd_addr;
   logic [MA_W-1:0]   wa;

   logic              ack_q;
   logic              err_q;
   logic [MA_W-1:0]   addr_d;
   logic              we_d;
   logic [PIX_W-1:0]  wdata_d;
   logic              ack_d;
   logic              err_d;

   logic              rd1;
   logic              bl1;
   logic              bl2;

   // The read is granted on the clk right after the strobe, so it never waits.
   assign disp_pend = pix_clk & draw_active;
   assign wr_ok     = ({1'b0, wr.wr_addr} < FB_SZ);
   assign wr_go     = wr.wr_req & ~ack_q & ~disp_pend;

   // Scan address: pix_y*FB_W as a sum of shifted copies, plus x offset.
   always_comb begin
      y_w   = ADDR_W'(pix_y);
      y_mul = '0;
      for (int i = 0; i < 32; i++) begin
         if (FB_W_V[i]) y_mul = y_mul + (y_w << i);
      end
      x_off     = ADDR_W'(pix_x) - ADDR_W'(H_DRAW_MIN);
      disp_addr = y_mul + x_off;
   end

`ifdef FB_DOUBLE_BUF_EN
   assign rd_addr = {front_sel, disp_addr};
   assign wa      = {~front_sel, wr.wr_addr};
`else
   assign rd_addr = disp_addr;
   assign wa      = wr.wr_addr;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) st_q <= IDLE;
      else      st_q <= st_d;
   end

   // Next state: display read first, writer only after a quiet clk.
   always_comb begin
      st_d = IDLE;
      unique case (1'b1)
         disp_pend: st_d = DRD;
         wr_go:     st_d = WR;
         default:   st_d = IDLE;
      endcase
   end

   // Next values of the registered RAM and handshake outputs.
   always_comb begin
      addr_d  = mem_addr;
      we_d    = 1'b0;
      wdata_d = mem_wdata;
      ack_d   = 1'b0;
      err_d   = err_q;
      unique case (st_d)
         DRD: begin
            addr_d = rd_addr;
         end
         WR: begin
            addr_d  = wa;
            we_d    = wr_ok;
            wdata_d = wr.wr_data;
            ack_d   = 1'b1;
            err_d   = err_q | ~wr_ok;
         end
         default: begin
         end
      endcase
   end

   // Output registers; reset kills any in-flight write at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         mem_addr  <= addr_d;
         mem_we    <= we_d;
         mem_wdata <= wdata_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
      end
   end

   assign wr.wr_ack = ack_q;
   assign wr.wr_err = err_q;

   // Two-deep sample pipe: read data or blank lands at strobe + 3.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd1       <= 1'b0;
         bl1       <= 1'b0;
         bl2       <= 1'b0;
         pix_data  <= '0;
         pix_valid <= 1'b0;
      end else begin
         rd1 <= (st_q == DRD);
         bl1 <= pix_clk & ~draw_active;
         bl2 <= bl1;
         if (bl2) begin
            pix_data  <= '0;
            pix_valid <= 1'b0;
         end else if (rd1) begin
            pix_data  <= mem_rdata;
            pix_valid <= 1'b1;
         end
      end
   end

`ifdef FB_DOUBLE_BUF_EN
   logic swap_hit;
   assign swap_hit = pix_clk & screen_end & swap_pending;

   // Buffer swap at frame end; a request in the swap clk waits a frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         front_sel    <= 1'b0;
         swap_pending <= 1'b0;
      end else if (swap_hit) begin
         front_sel    <= ~front_sel;
         swap_pending <= swap_req;
      end else if (swap_req) begin
         swap_pending <= 1'b1;
      end
   end
`endif

endmodule
